// File: rtl/fft_ctrl.sv
// rtl/fft_ctrl.sv - address sequencer for an in-place radix-2 DIT FFT
// Loads bit-reversed, issues every butterfly per stage, drains, then unloads in natural order.
module fft_ctrl #(
  parameter int FFT_POINTS   = 1024,
  parameter int LOG2_POINTS  = 10,
  parameter int BFLY_LATENCY = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           wr_en,
  output logic [LOG2_POINTS-1:0]         wr_addr,
  output logic                           bf_valid,
  output logic [LOG2_POINTS-1:0]         bf_addr_a,
  output logic [LOG2_POINTS-1:0]         bf_addr_b,
  output logic [LOG2_POINTS-2:0]         bf_tw_addr,
  output logic [$clog2(LOG2_POINTS)-1:0] stage,
  output logic                           rd_en,
  output logic [LOG2_POINTS-1:0]         rd_addr,
  output logic                           out_valid
);

  localparam int L  = LOG2_POINTS;
  localparam int SW = $clog2(LOG2_POINTS);
  localparam int DW = $clog2(BFLY_LATENCY + 1);

  localparam logic [L-1:0]  LAST_K = L'(FFT_POINTS - 1);
  localparam logic [L-1:0]  LAST_B = L'(FFT_POINTS / 2 - 1);
  localparam logic [SW-1:0] LAST_S = SW'(LOG2_POINTS - 1);
  localparam logic [DW-1:0] LAST_D = DW'(BFLY_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_UNLOAD,
    S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [L-1:0]  idx_q, idx_d;
  logic [SW-1:0] s_q, s_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          out_valid_q, out_valid_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      s_q         <= '0;
      drain_q     <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s_q         <= s_d;
      drain_q     <= drain_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // idx_q is shared: load count k, butterfly index b, and unload address.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    s_d         = s_q;
    drain_d     = drain_q;
    out_valid_d = (state_q == S_UNLOAD);
    done_d      = (state_q == S_FINISH);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          s_d     = '0;
          drain_d = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (idx_q == LAST_K) begin
            state_d = S_COMPUTE;
            idx_d   = '0;
            s_d     = '0;
          end else begin
            idx_d = idx_q + L'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (idx_q == LAST_B) begin
          state_d = S_DRAIN;
          idx_d   = '0;
          drain_d = '0;
        end else begin
          idx_d = idx_q + L'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_D) begin
          drain_d = '0;
          idx_d   = '0;
          if (s_q == LAST_S) begin
            state_d = S_UNLOAD;
            s_d     = '0;
          end else begin
            state_d = S_COMPUTE;
            s_d     = s_q + SW'(1);
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_UNLOAD: begin
        if (idx_q == LAST_K) begin
          state_d = S_FINISH;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + L'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic [L-2:0]  b_lo, pos, grp, span_mask, tw;
  logic [L-1:0]  span, addr_a, addr_b, rev_k;
  logic [SW-1:0] tw_shift;

  // b < N/2 always fits in L-1 bits; group base is grp * 2 * span.
  always_comb begin
    b_lo      = idx_q[L-2:0];
    span_mask = ~({(L-1){1'b1}} << s_q);
    pos       = b_lo & span_mask;
    grp       = b_lo >> s_q;
    span      = {{(L-1){1'b0}}, 1'b1} << s_q;
    addr_a    = ({grp, 1'b0} << s_q) | {1'b0, pos};
    addr_b    = addr_a + span;
    tw_shift  = LAST_S - s_q;
    tw        = pos << tw_shift;
    rev_k     = '0;
    for (int j = 0; j < L; j++) begin
      rev_k[j] = idx_q[L-1-j];
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign in_ready   = (state_q == S_LOAD);
  assign wr_en      = in_valid & in_ready;
  assign wr_addr    = in_ready ? rev_k : '0;
  assign bf_valid   = (state_q == S_COMPUTE);
  assign bf_addr_a  = bf_valid ? addr_a : '0;
  assign bf_addr_b  = bf_valid ? addr_b : '0;
  assign bf_tw_addr = bf_valid ? tw : '0;
  assign stage      = (state_q == S_COMPUTE || state_q == S_DRAIN) ? s_q : '0;
  assign rd_en      = (state_q == S_UNLOAD);
  assign rd_addr    = rd_en ? idx_q : '0;
  assign out_valid  = out_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fft_ctrl.sv
// tb/tb_fft_ctrl.sv - self-checking bench for fft_ctrl at N=8
// Expected traces come from the transform's address rules applied with plain arithmetic.
module tb_fft_ctrl;

  localparam int N   = 8;
  localparam int L   = 3;
  localparam int LAT = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic         in_valid;
  logic         in_ready;
  logic         wr_en;
  logic [L-1:0] wr_addr;
  logic         bf_valid;
  logic [L-1:0] bf_addr_a;
  logic [L-1:0] bf_addr_b;
  logic [L-2:0] bf_tw_addr;
  logic [1:0]   stage;
  logic         rd_en;
  logic [L-1:0] rd_addr;
  logic         out_valid;

  fft_ctrl #(
    .FFT_POINTS  (N),
    .LOG2_POINTS (L),
    .BFLY_LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .bf_valid  (bf_valid),
    .bf_addr_a (bf_addr_a),
    .bf_addr_b (bf_addr_b),
    .bf_tw_addr(bf_tw_addr),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [22:0] all_outs;
  assign all_outs = {busy, done, in_ready, wr_en, wr_addr, bf_valid, bf_addr_a, bf_addr_b,
                     bf_tw_addr, stage, rd_en, rd_addr, out_valid};

  typedef struct { logic iv; logic en; int addr; logic rdy; } ld_vec_t;
  typedef struct { int st; int b; int a; int bb; int tw; } bf_vec_t;
  typedef struct { int cyc; int addr; } addr_rec_t;
  typedef struct { int cyc; int st; int a; int b; int tw; } bf_rec_t;

  ld_vec_t   ld_tbl[11];
  bf_vec_t   bf_tbl[4];
  addr_rec_t wr_q[$];
  addr_rec_t rd_q[$];
  bf_rec_t   bf_q[$];
  int        ov_q[$];
  int        done_q[$];
  int        busy_cnt;
  int        ir_cnt;
  int        n_checks = 0;
  int        n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bitrev(input int k);
    int r;
    r = 0;
    for (int j = 0; j < L; j++) r = r * 2 + ((k >> j) & 1);
    return r;
  endfunction

  task automatic sample();
    addr_rec_t ar;
    bf_rec_t   br;
    if (wr_en) begin
      ar.cyc = cyc; ar.addr = int'(wr_addr); wr_q.push_back(ar);
    end
    if (bf_valid) begin
      br.cyc = cyc; br.st = int'(stage); br.a = int'(bf_addr_a);
      br.b = int'(bf_addr_b); br.tw = int'(bf_tw_addr); bf_q.push_back(br);
    end
    if (rd_en) begin
      ar.cyc = cyc; ar.addr = int'(rd_addr); rd_q.push_back(ar);
    end
    if (out_valid) ov_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (busy) busy_cnt++;
    if (in_ready) ir_cnt++;
  endtask

  // mode 0: in_valid held high, 1: table with a gap, 2: random gaps.
  task automatic run_xfer(input int mode, input bit pulse_mid, input bit chain);
    int s0, acc, load_end, cs, us, m, st, b, span, pos, grp, ea;
    int acc_cyc[N];
    bit got_done;
    wr_q.delete(); rd_q.delete(); bf_q.delete(); ov_q.delete(); done_q.delete();
    busy_cnt = 0; ir_cnt = 0;
    s0 = cyc; start = 1'b1; in_valid = 1'b0;
    acc = 0; load_end = -1; got_done = 1'b0;
    for (int i = 0; i < 4000 && !got_done; i++) begin
      tick();
      start = 1'b0;
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (i < 11) ? ld_tbl[i].iv : 1'b0;
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      if (acc < N && in_valid) begin
        acc_cyc[acc] = cyc;
        acc++;
        if (acc == N) load_end = cyc;
      end
      if (pulse_mid && load_end >= 0 && cyc == load_end + 3) start = 1'b1;
      #1;
      if (i == 0) chk("in_ready_after_start", int'(in_ready), 1);
      if (mode == 1 && i < 11) begin
        chk("tbl_wr_en", int'(wr_en), int'(ld_tbl[i].en));
        chk("tbl_wr_addr", int'(wr_addr), ld_tbl[i].addr);
        chk("tbl_in_ready", int'(in_ready), int'(ld_tbl[i].rdy));
      end
      sample();
      if (done) got_done = 1'b1;
    end
    chk("done_seen", int'(got_done), 1);
    if (got_done) chk("busy_low_at_done", int'(busy), 0);

    cs = load_end + 1;
    us = cs + L * (N / 2 + LAT);
    chk("wr_count", wr_q.size(), N);
    m = (wr_q.size() < N) ? wr_q.size() : N;
    for (int k = 0; k < m; k++) begin
      chk("wr_addr_seq", wr_q[k].addr, bitrev(k));
      chk("wr_cycle", wr_q[k].cyc, acc_cyc[k]);
    end
    chk("in_ready_cycles", ir_cnt, load_end - s0);
    chk("bf_count", bf_q.size(), L * N / 2);
    m = (bf_q.size() < L * N / 2) ? bf_q.size() : L * N / 2;
    for (int e = 0; e < m; e++) begin
      st = e / (N / 2); b = e % (N / 2);
      span = 1 << st; pos = b % span; grp = b / span;
      ea = grp * 2 * span + pos;
      chk("bf_stage", bf_q[e].st, st);
      chk("bf_addr_a", bf_q[e].a, ea);
      chk("bf_addr_b", bf_q[e].b, ea + span);
      chk("bf_tw", bf_q[e].tw, pos * (1 << (L - 1 - st)));
      chk("bf_cycle", bf_q[e].cyc, cs + st * (N / 2 + LAT) + b);
    end
    chk("rd_count", rd_q.size(), N);
    m = (rd_q.size() < N) ? rd_q.size() : N;
    for (int k = 0; k < m; k++) begin
      chk("rd_addr_seq", rd_q[k].addr, k);
      chk("rd_cycle", rd_q[k].cyc, us + k);
    end
    chk("ov_count", ov_q.size(), N);
    m = (ov_q.size() < N) ? ov_q.size() : N;
    for (int k = 0; k < m; k++) chk("ov_cycle", ov_q[k], us + 1 + k);
    chk("done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("done_cycle", done_q[0], us + N + 1);
    if (done_q.size() > 0) chk("start_to_done", done_q[0] - s0, 1 + (load_end - s0) + 24 + N + 1);
    chk("busy_cycles", busy_cnt, us + N - s0);

    if (!chain) begin
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        #1;
        chk("idle_after_done", int'(all_outs), 0);
      end
    end
  endtask

  int r_s0;
  int idx;

  initial begin
    ld_tbl[0]  = '{1'b1, 1'b1, 0, 1'b1};
    ld_tbl[1]  = '{1'b1, 1'b1, 4, 1'b1};
    ld_tbl[2]  = '{1'b1, 1'b1, 2, 1'b1};
    ld_tbl[3]  = '{1'b1, 1'b1, 6, 1'b1};
    ld_tbl[4]  = '{1'b0, 1'b0, 1, 1'b1};
    ld_tbl[5]  = '{1'b0, 1'b0, 1, 1'b1};
    ld_tbl[6]  = '{1'b1, 1'b1, 1, 1'b1};
    ld_tbl[7]  = '{1'b1, 1'b1, 5, 1'b1};
    ld_tbl[8]  = '{1'b1, 1'b1, 3, 1'b1};
    ld_tbl[9]  = '{1'b1, 1'b1, 7, 1'b1};
    ld_tbl[10] = '{1'b1, 1'b0, 0, 1'b0};
    bf_tbl[0]  = '{0, 2, 4, 5, 0};
    bf_tbl[1]  = '{1, 1, 1, 3, 2};
    bf_tbl[2]  = '{2, 3, 3, 7, 3};
    bf_tbl[3]  = '{2, 0, 0, 4, 0};

    rst = 1'b1; start = 1'b1; in_valid = 1'b1;
    tick();
    chk("reset_hold_1", int'(all_outs), 0);
    tick();
    chk("reset_hold_2", int'(all_outs), 0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick();
    chk("idle_after_reset", int'(all_outs), 0);

    run_xfer(0, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      idx = bf_tbl[t].st * (N / 2) + bf_tbl[t].b;
      if (idx < bf_q.size()) begin
        chk("vec_bf_a", bf_q[idx].a, bf_tbl[t].a);
        chk("vec_bf_b", bf_q[idx].b, bf_tbl[t].bb);
        chk("vec_bf_tw", bf_q[idx].tw, bf_tbl[t].tw);
      end else begin
        chk("vec_bf_present", bf_q.size(), idx + 1);
      end
    end

    run_xfer(1, 1'b0, 1'b0);
    run_xfer(0, 1'b1, 1'b1);
    run_xfer(2, 1'b0, 1'b0);

    r_s0 = cyc; start = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b1;
    while (cyc < r_s0 + 19) begin
      tick();
      if (cyc > r_s0 + 8) in_valid = 1'b0;
    end
    #1;
    chk("mid_stage", int'(stage), 1);
    chk("mid_bf_valid", int'(bf_valid), 1);
    chk("mid_bf_a", int'(bf_addr_a), 4);
    chk("mid_bf_b", int'(bf_addr_b), 6);
    chk("mid_bf_tw", int'(bf_tw_addr), 0);
    rst = 1'b1;
    tick();
    chk("reset_mid_compute", int'(all_outs), 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      #1;
      chk("no_done_after_reset", int'(all_outs), 0);
    end

    run_xfer(0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) run_xfer(2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
